ra_return_stack: RTL and testbench
==================================

// Module: ra_return_stack
// PURPOSE
// Return-address predictor and reader on the consumer side of $ra (r31). The writeback path commits
// architectural $ra; this block tracks speculative return addresses from jal in decode and predicts
// jr $31 targets. It checks each prediction against the resolved target from execute.
// Sits between decode (push/pop), execute (resolve) and the X/M $ra write path (arch update).
// PARAMETERS
// DEPTH  8   stack entries (power of 2, >=2); pointer width = log2(DEPTH)
// WIDTH  32  address/data width
// PORTS
// clock           in   1      system clock, rising edge
// reset           in   1      asynchronous, active-low; 0 = reset asserted
// flush           in   1      pipeline flush (branch/jump mispredict); clears speculative stack
// push_valid      in   1      jal in decode this cycle
// push_addr       in   WIDTH  jal return address (pc+1)
// pop_valid       in   1      jr with rs==31 in decode this cycle
// resolve_valid   in   1      jr reaches execute this cycle
// resolve_target  in   WIDTH  actual jr target (forwarded $ra value)
// ra_write_en     in   1      architectural $ra write enable from X/M
// ra_write_data   in   WIDTH  architectural $ra value
// pred_target     out  WIDTH  predicted jr target, combinational, valid when pop_valid
// pred_from_stack out  1      1 = pred_target came from stack; 0 = from arch $ra path
// mispredict      out  1      registered one-cycle pulse: resolved target != prediction
// empty           out  1      stack count == 0
// full            out  1      stack count == DEPTH
// BEHAVIOUR
// - Reset (reset==0, async): count=0, top ptr=0, arch_ra=0, pend_valid=0, pend_target=0,
//   mispredict=0; so empty=1, full=0, pred_target=0, pred_from_stack=0.
// - Storage: circular array of DEPTH entries, top ptr, count 0..DEPTH. Entries are not cleared on reset or flush.
// - pred_target (comb): if count>0, mem[top] with pred_from_stack=1. Else if ra_write_en, ra_write_data
//   (bypass). Else arch_ra. pred_from_stack=0 in both non-stack cases.
// - Per-cycle update, priority order:
//   1. flush: count<=0. push/pop that cycle are ignored. arch_ra and pending updates still apply.
//   2. push & pop: mem[top]<=push_addr; ptr and count unchanged. Prediction uses the old top.
//   3. push only: ptr<=ptr+1 (mod DEPTH); mem[ptr+1]<=push_addr; count<=min(count+1,DEPTH).
//      When full, the oldest entry is overwritten silently.
//   4. pop only: if count>0, ptr<=ptr-1 (mod DEPTH) and count<=count-1. If empty, no state change.
// - arch_ra <= ra_write_data when ra_write_en, regardless of flush.
// - Pending check: one prediction tracked.
//   - pop_valid & !flush: pend_target<=pred_target, pend_valid<=1.
//   - resolve_valid & no new pop: pend_valid<=0.
//   - resolve and pop in the same cycle: compare against the old pending, then load the new one.
// - mispredict: on the cycle after resolve_valid, mispredict=1 if (!pend_valid | pend_target!=resolve_target);
//   otherwise 0. Exactly one cycle wide. resolve during flush is still checked.
// - Latency: prediction 0 cycles (comb). Stack/arch update 1 cycle. mispredict 1 cycle after resolve.
// - Equality is full WIDTH. No arithmetic on addresses. Pointer wrap is modulo DEPTH only.
// TESTING
// 1. Release reset, push 0x10,0x20,0x30 on successive cycles, then pop x3 -> pred_target 0x30,0x20,0x10,
//    pred_from_stack=1, empty=1 after the third pop.
// 2. DEPTH=8: push 0x1..0x9 (9 pushes) -> full=1 after the 8th. Pop x8 -> 0x9..0x2. A 9th pop gives
//    pred_from_stack=0, pred_target=arch_ra.
// 3. Empty stack, ra_write_en=1, ra_write_data=0x44, pop same cycle -> pred_target=0x44. Next-cycle
//    pop -> 0x44 from arch_ra.
// 4. Stack top 0x30, push 0x50 & pop same cycle -> pred 0x30, count unchanged, next pop -> 0x50.
// 5. Pop predicts 0x20, resolve 0x20 -> mispredict=0. Pop predicts 0x10, resolve 0x11 -> mispredict=1 for
//    exactly one cycle. resolve with no pending -> mispredict=1.
// 6. Push x3, flush, pop -> from arch path (empty=1). Assert reset mid-push -> all outputs at reset values
//    immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ra_return_stack.sv
// rtl/ra_return_stack.sv - speculative return-address stack predicting jr $31 targets
module ra_return_stack #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_push_valid,
    input  logic [WIDTH-1:0] i_push_addr,
    input  logic             i_pop_valid,
    input  logic             i_resolve_valid,
    input  logic [WIDTH-1:0] i_resolve_target,
    input  logic             i_ra_write_en,
    input  logic [WIDTH-1:0] i_ra_write_data,
    output logic [WIDTH-1:0] o_pred_target,
    output logic             o_pred_from_stack,
    output logic             o_mispredict,
    output logic             o_empty,
    output logic             o_full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_top;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_arch_ra;
    logic             r_pend_valid;
    logic [WIDTH-1:0] r_pend_target;
    logic             r_mispredict;

    logic [PW-1:0]    w_top_inc;
    logic [PW-1:0]    w_top_dec;
    logic             w_do_push_pop;
    logic             w_do_push;
    logic             w_do_pop;
    logic             w_mem_we;
    logic [PW-1:0]    w_mem_addr;

    assign w_top_inc     = r_top + PW'(1);
    assign w_top_dec     = r_top - PW'(1);
    assign w_do_push_pop = !i_flush && i_push_valid && i_pop_valid;
    assign w_do_push     = !i_flush && i_push_valid && !i_pop_valid;
    assign w_do_pop      = !i_flush && !i_push_valid && i_pop_valid && (r_count != '0);
    assign w_mem_we      = w_do_push_pop || w_do_push;
    assign w_mem_addr    = w_do_push ? w_top_inc : r_top;

    // Stack top wins; otherwise an in-flight $ra write is bypassed ahead of the committed copy.
    always_comb begin
        o_pred_target     = r_arch_ra;
        o_pred_from_stack = 1'b0;
        if (r_count != '0) begin
            o_pred_target     = r_mem[r_top];
            o_pred_from_stack = 1'b1;
        end else if (i_ra_write_en) begin
            o_pred_target = i_ra_write_data;
        end
    end

    assign o_empty      = (r_count == '0);
    assign o_full       = (r_count == C_FULL);
    assign o_mispredict = r_mispredict;

    always_ff @(posedge i_clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= i_push_addr;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_top   <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_count <= '0;
        end else if (w_do_push) begin
            r_top <= w_top_inc;
            if (r_count != C_FULL) begin
                r_count <= r_count + CW'(1);
            end
        end else if (w_do_pop) begin
            r_top   <= w_top_dec;
            r_count <= r_count - CW'(1);
        end
    end

    // The compare uses the pending prediction from before this cycle's pop reloads it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_arch_ra     <= '0;
            r_pend_valid  <= 1'b0;
            r_pend_target <= '0;
            r_mispredict  <= 1'b0;
        end else begin
            if (i_ra_write_en) begin
                r_arch_ra <= i_ra_write_data;
            end
            if (i_pop_valid && !i_flush) begin
                r_pend_valid  <= 1'b1;
                r_pend_target <= o_pred_target;
            end else if (i_resolve_valid) begin
                r_pend_valid <= 1'b0;
            end
            r_mispredict <= i_resolve_valid &&
                            (!r_pend_valid || (r_pend_target != i_resolve_target));
        end
    end
endmodule

// File: tb/tb_ra_return_stack.sv
// tb/tb_ra_return_stack.sv - randomized and directed bench for ra_return_stack
module tb_ra_return_stack;
    localparam int DEPTH = 8;
    localparam int WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             push_valid;
    logic [WIDTH-1:0] push_addr;
    logic             pop_valid;
    logic             resolve_valid;
    logic [WIDTH-1:0] resolve_target;
    logic             ra_write_en;
    logic [WIDTH-1:0] ra_write_data;
    logic [WIDTH-1:0] pred_target;
    logic             pred_from_stack;
    logic             mispredict;
    logic             empty;
    logic             full;

    int n_tests = 0;
    int n_fail  = 0;

    logic [WIDTH-1:0] m_stk[$];
    logic [WIDTH-1:0] m_arch;
    logic             m_pv;
    logic [WIDTH-1:0] m_pt;
    logic             m_mis;

    ra_return_stack #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_flush          (flush),
        .i_push_valid     (push_valid),
        .i_push_addr      (push_addr),
        .i_pop_valid      (pop_valid),
        .i_resolve_valid  (resolve_valid),
        .i_resolve_target (resolve_target),
        .i_ra_write_en    (ra_write_en),
        .i_ra_write_data  (ra_write_data),
        .o_pred_target    (pred_target),
        .o_pred_from_stack(pred_from_stack),
        .o_mispredict     (mispredict),
        .o_empty          (empty),
        .o_full           (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_stk.delete();
        m_arch = '0;
        m_pv   = 1'b0;
        m_pt   = '0;
        m_mis  = 1'b0;
    endtask

    function automatic logic [WIDTH-1:0] model_pred();
        if (m_stk.size() > 0) return m_stk[m_stk.size()-1];
        if (ra_write_en) return ra_write_data;
        return m_arch;
    endfunction

    task automatic check_outputs(input string ctx);
        check({ctx, ".pred"},  pred_target, model_pred());
        check({ctx, ".fstk"},  WIDTH'(pred_from_stack), WIDTH'(m_stk.size() > 0));
        check({ctx, ".empty"}, WIDTH'(empty), WIDTH'(m_stk.size() == 0));
        check({ctx, ".full"},  WIDTH'(full), WIDTH'(m_stk.size() == DEPTH));
        check({ctx, ".misp"},  WIDTH'(mispredict), WIDTH'(m_mis));
    endtask

    // Inputs are driven while the clock is low; the model advances alongside the edge.
    task automatic step(input logic f, input logic pu, input logic [WIDTH-1:0] pa, input logic po,
                        input logic rv, input logic [WIDTH-1:0] rt,
                        input logic we, input logic [WIDTH-1:0] wd, input string ctx);
        logic [WIDTH-1:0] pred;
        flush = f; push_valid = pu; push_addr = pa; pop_valid = po;
        resolve_valid = rv; resolve_target = rt; ra_write_en = we; ra_write_data = wd;
        #1;
        check_outputs(ctx);
        pred  = model_pred();
        m_mis = rv && (!m_pv || (m_pt != rt));
        if (po && !f) begin
            m_pv = 1'b1;
            m_pt = pred;
        end else if (rv) begin
            m_pv = 1'b0;
        end
        if (f) begin
            m_stk.delete();
        end else if (pu && po) begin
            if (m_stk.size() > 0) m_stk[m_stk.size()-1] = pa;
        end else if (pu) begin
            m_stk.push_back(pa);
            if (m_stk.size() > DEPTH) void'(m_stk.pop_front());
        end else if (po) begin
            if (m_stk.size() > 0) void'(m_stk.pop_back());
        end
        if (we) m_arch = wd;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input string ctx);
        step(0, 0, 0, 0, 0, 0, 0, 0, ctx);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        flush = 0; push_valid = 0; push_addr = 0; pop_valid = 0;
        resolve_valid = 0; resolve_target = 0; ra_write_en = 0; ra_write_data = 0;
        @(negedge clk);
        do_reset();

        // LIFO order
        step(0, 1, 32'h10, 0, 0, 0, 0, 0, "t1.push");
        step(0, 1, 32'h20, 0, 0, 0, 0, 0, "t1.push");
        step(0, 1, 32'h30, 0, 0, 0, 0, 0, "t1.push");
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0, 0, 0, "t1.pop");
        idle("t1.end");

        // overflow wraps and drops the oldest
        for (int i = 1; i <= 9; i++) step(0, 1, WIDTH'(i), 0, 0, 0, 0, 0, "t2.push");
        for (int i = 0; i < 9; i++) step(0, 0, 0, 1, 0, 0, 0, 0, "t2.pop");
        idle("t2.end");

        // arch bypass then committed value
        step(0, 0, 0, 1, 0, 0, 1, 32'h44, "t3.byp");
        step(0, 0, 0, 1, 0, 0, 0, 0, "t3.arch");
        idle("t3.end");

        // push and pop together replace the top
        step(0, 1, 32'h30, 0, 0, 0, 0, 0, "t4.push");
        step(0, 1, 32'h50, 1, 0, 0, 0, 0, "t4.pp");
        step(0, 0, 0, 1, 0, 0, 0, 0, "t4.pop");

        // resolve checks
        step(0, 1, 32'h10, 0, 0, 0, 0, 0, "t5.push");
        step(0, 1, 32'h20, 0, 0, 0, 0, 0, "t5.push");
        step(0, 0, 0, 1, 0, 0, 0, 0, "t5.pop");
        step(0, 0, 0, 0, 1, 32'h20, 0, 0, "t5.res_ok");
        step(0, 0, 0, 1, 0, 0, 0, 0, "t5.pop");
        step(0, 0, 0, 0, 1, 32'h11, 0, 0, "t5.res_bad");
        idle("t5.pulse");
        step(0, 0, 0, 0, 1, 32'h11, 0, 0, "t5.res_none");
        idle("t5.pulse2");
        idle("t5.end");

        // flush empties, then async reset mid-push
        for (int i = 0; i < 3; i++) step(0, 1, WIDTH'(32'h70 + i), 0, 0, 0, 0, 0, "t6.push");
        step(1, 0, 0, 0, 0, 0, 0, 0, "t6.flush");
        step(0, 0, 0, 1, 0, 0, 0, 0, "t6.pop");
        step(0, 1, 32'h99, 0, 0, 0, 1, 32'h5, "t6.push");
        push_valid = 1; push_addr = 32'hAB;
        do_reset();
        idle("t6.after");

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [WIDTH-1:0] rt;
            rt = ($urandom_range(0, 1) == 1 && m_pv) ? m_pt : WIDTH'($urandom_range(0, 15));
            step($urandom_range(0, 19) == 0,
                 $urandom_range(0, 9) < 4, WIDTH'($urandom_range(0, 255)),
                 $urandom_range(0, 9) < 4,
                 $urandom_range(0, 9) < 3, rt,
                 $urandom_range(0, 9) < 2, WIDTH'($urandom_range(0, 15)), "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
